ld_st_issue_station: RTL and testbench
======================================

# ld_st_issue_station

Parametrised load/store reservation station that replaces the fixed-depth, single-operand load/store queue in the out-of-order back end. It allocates its own slots, tracks base (rs1) and store-data (rs2) operand readiness from N common data buses, and enforces store-tag ordering for loads. It squashes on branch mispredict and issues the oldest ready entry to the address-generation unit through a valid/ready handshake. It sits between dispatch/rename and the load/store AGU/PRF read stage.

## Interface
- QUEUE_DEPTH, 8, number of entries; power of two, ≥2
- NUM_CDB, 2, number of CDB wakeup ports; ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- alloc_valid  in  1  dispatch presents a packet
- alloc_pkt  in  ld_st_data_pkt_t  renamed packet (rs1/rs2 paddr, use bits, rdy bits, bmask, store_tag, is_store)
- alloc_ready  out  1  at least one free entry
- cdb_pkt  in  cdb_pkt_t[NUM_CDB]  wakeup broadcasts
- br_pkt  in  br_resolve_pkt_t  branch resolve: valid, mispred, br_bit
- st_tag_pkt  in  st_tag_pkt_t  store-tag done broadcast
- iss_valid  out  1  an entry is selected for issue
- iss_ready  in  1  AGU accepts
- iss_pkt  out  ld_st_data_pkt_t  selected entry, bmask already updated for this cycle's resolve
- prf_ren_pkt  out  reg_ren_pkt_t  rs1/rs2 read enables for the issuing entry, asserted only on issue fire
- prf_addr_pkt  out  reg_addr_pkt_t  rs1/rs2 paddr of issuing entry, zero when not firing
- occupancy  out  $clog2(QUEUE_DEPTH)+1  valid entry count

## Operation
- Allocation: on alloc_valid && alloc_ready, write lowest-index free entry; the new entry becomes younger than every currently valid entry.
- Allocation filtering, same cycle: incoming rs1/rs2 compared against all CDBs; matches set rdy. br_pkt applies to the incoming bmask; on mispredict with its bit set, the packet is dropped (no write, still counts as accepted); on correct prediction, the bit is cleared before write. A matching st_tag sets store_tag_done.
- Wakeup: for each valid entry, any CDB with cdb_broadcast and paddr equal to a used source sets that source's rdy. Unused sources count as ready. paddr 0 never wakes.
- Eligibility: valid, not killed this cycle, rs1 ready; stores also need rs2 ready; loads also need store_tag_done.
- Select: oldest eligible entry, chosen by age matrix. iss_valid = any eligible.
- Issue fire = iss_valid && iss_ready. The entry is cleared at the edge. iss_pkt and PRF read signals must remain stable while iss_valid && !iss_ready unless a mispredict kills the entry or an older entry becomes eligible.
- Mispredict: br_pkt.valid && mispred invalidates every entry with bmask[br_bit] set at the edge and masks those entries from select in the same cycle. Correct resolve clears bmask[br_bit] in all entries.
- Age matrix: row i bit j = 1 means j is older than i. On alloc, set row to the current valid vector and clear column. Freed entries keep stale bits, which are masked by valid.

## Timing
- Reset: all entries invalid, age matrix zero, alloc_ready=1, iss_valid=0, occupancy=0, prf outputs 0.
- Alloc to issue: minimum 1 cycle (entry written at edge, eligible in the next cycle).
- CDB to issue: 0 cycles with bypass (see Configuration), otherwise 1 cycle.
- alloc_ready depends only on registered occupancy. A slot freed in cycle t is allocatable in cycle t+1. When full, a simultaneous issue does not allow same-cycle alloc.
- Reset asserted mid-operation clears state immediately. No issue fire occurs in the reset cycle.
- Issue and alloc in the same cycle never target the same slot, because alloc uses only currently free slots.

## Configuration
- LSIQ_CDB_BYPASS_EN defined: same-cycle CDB matches count toward eligibility, so an entry woken in cycle t may issue in cycle t.
- Undefined: eligibility uses registered rdy bits only, giving a 1-cycle wakeup-to-issue delay and a shorter critical path.

## Structure
- rv32i_types: ld_st_data_pkt_t extended with rs2_paddr, i_use_rs2, rs2_rdy, and is_store; br_resolve_pkt_t; the existing cdb_pkt_t, st_tag_pkt_t, reg_addr_pkt_t, and reg_ren_pkt_t.
- Sub-module lsiq_age_matrix(QUEUE_DEPTH) takes the alloc one-hot, valid vector, and eligible vector and returns the oldest one-hot; its state resets asynchronously.
- Free-slot pick and one-hot to index conversion live in the top module.

## Test plan
- Fill 8 loads with rs1 ready and store_tag_done=1, iss_ready=1 -> issue in allocation order 0..7 over 8 cycles; alloc_ready=0 when occupancy=8.
- Store with rs1 ready and rs2 not ready (rs2_paddr=12); CDB1 broadcasts 12 -> iss_valid in the same cycle with bypass, the next cycle without; prf_ren asserts rs1 and rs2.
- Load with store_tag=3 not done, older store ready -> store issues first; st_tag 3 broadcast -> load issues the following cycle.
- Entries A (bmask bit 2) and B (no bit 2); mispredict on br_bit=2 -> A never issues, B issues, occupancy drops by 1 at the edge.
- alloc_valid with rs1_paddr=5 not ready, same cycle CDB0 broadcasts 5 -> entry stored ready and issues in the next cycle.
- iss_ready held low 3 cycles -> iss_pkt stable; rst pulsed low mid-stall -> iss_valid=0 and occupancy=0 immediately.

Source files
------------

// File: rtl/ld_st_issue_station_pkg.sv
// Shared packet types for the load/store issue station: dispatch packet,
// CDB wakeup, branch resolve, store-tag done and PRF read request.
package ld_st_issue_station_pkg;

    localparam int PADDR_W  = 6;
    localparam int BMASK_W  = 4;
    localparam int BR_BIT_W = 2;
    localparam int ST_TAG_W = 4;

    typedef struct packed {
        logic [PADDR_W-1:0]  rd_paddr;
        logic [PADDR_W-1:0]  rs1_paddr;
        logic [PADDR_W-1:0]  rs2_paddr;
        logic                i_use_rs1;
        logic                i_use_rs2;
        logic                rs1_rdy;
        logic                rs2_rdy;
        logic [BMASK_W-1:0]  bmask;
        logic [ST_TAG_W-1:0] store_tag;
        logic                store_tag_done;
        logic                is_store;
    } ld_st_data_pkt_t;

    typedef struct packed {
        logic               cdb_broadcast;
        logic [PADDR_W-1:0] paddr;
    } cdb_pkt_t;

    typedef struct packed {
        logic                valid;
        logic                mispred;
        logic [BR_BIT_W-1:0] br_bit;
    } br_resolve_pkt_t;

    typedef struct packed {
        logic                valid;
        logic [ST_TAG_W-1:0] store_tag;
    } st_tag_pkt_t;

    typedef struct packed {
        logic [PADDR_W-1:0] rs1_paddr;
        logic [PADDR_W-1:0] rs2_paddr;
    } reg_addr_pkt_t;

    typedef struct packed {
        logic rs1_ren;
        logic rs2_ren;
    } reg_ren_pkt_t;

    // A source the instruction does not read never blocks issue.
    function automatic logic src_ready(input logic use_src, input logic rdy);
        return !use_src || rdy;
    endfunction

endpackage

// File: rtl/lsiq_age_matrix.sv
// Age matrix for the issue station: row i bit j set means entry j is older
// than entry i; returns the oldest eligible entry as a one-hot.
module lsiq_age_matrix #(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [QUEUE_DEPTH-1:0] alloc_oh,
    input  logic [QUEUE_DEPTH-1:0] valid,
    input  logic [QUEUE_DEPTH-1:0] eligible,
    output logic [QUEUE_DEPTH-1:0] oldest_oh
);

    logic [QUEUE_DEPTH-1:0] row_q [QUEUE_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) row_q[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (alloc_oh[i]) row_q[i] <= valid;
                else             row_q[i] <= row_q[i] & ~alloc_oh;
            end
        end
    end

    // Stale bits from freed slots are harmless: they are masked by valid.
    always_comb begin
        oldest_oh = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            oldest_oh[i] = eligible[i] && !(|(row_q[i] & eligible & valid));
    end

endmodule

// File: rtl/ld_st_issue_station.sv
// Load/store reservation station: slot allocation, rs1/rs2 wakeup, store-tag
// ordering, branch squash and oldest-first issue. LSIQ_CDB_BYPASS_EN adds same-cycle CDB wakeup.
module ld_st_issue_station
    import ld_st_issue_station_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int NUM_CDB     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    input  ld_st_data_pkt_t              alloc_pkt,
    output logic                         alloc_ready,
    input  cdb_pkt_t                     cdb_pkt [NUM_CDB],
    input  br_resolve_pkt_t              br_pkt,
    input  st_tag_pkt_t                  st_tag_pkt,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output ld_st_data_pkt_t              iss_pkt,
    output reg_ren_pkt_t                 prf_ren_pkt,
    output reg_addr_pkt_t                prf_addr_pkt,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    ld_st_data_pkt_t        entry_q [QUEUE_DEPTH];
    ld_st_data_pkt_t        entry_d [QUEUE_DEPTH];
    ld_st_data_pkt_t        in_pkt;
    logic [QUEUE_DEPTH-1:0] valid_q, valid_d, eligible, killed;
    logic [QUEUE_DEPTH-1:0] free_vec, free_oh, alloc_oh, oldest_oh;
    logic [QUEUE_DEPTH-1:0] wake1, wake2;
    logic [CNT_W-1:0]       occ_q;
    logic [IDX_W-1:0]       sel_idx;
    logic                   br_kill, br_clear, in_killed, alloc_fire, iss_fire;
    logic                   rs1_now, rs2_now;

    function automatic logic cdb_match(input logic [PADDR_W-1:0] paddr);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < NUM_CDB; c++)
            if (cdb_pkt[c].cdb_broadcast && cdb_pkt[c].paddr == paddr && paddr != '0)
                hit = 1'b1;
        return hit;
    endfunction

    assign br_kill     = br_pkt.valid && br_pkt.mispred;
    assign br_clear    = br_pkt.valid && !br_pkt.mispred;
    assign alloc_ready = (occ_q != CNT_W'(QUEUE_DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign occupancy   = occ_q;

    // Lowest-index free slot.
    assign free_vec  = ~valid_q;
    assign free_oh   = free_vec & (~free_vec + QUEUE_DEPTH'(1));
    assign in_killed = br_kill && alloc_pkt.bmask[br_pkt.br_bit];
    assign alloc_oh  = (alloc_fire && !in_killed) ? free_oh : '0;

    always_comb begin
        in_pkt         = alloc_pkt;
        in_pkt.rs1_rdy = alloc_pkt.rs1_rdy | cdb_match(alloc_pkt.rs1_paddr);
        in_pkt.rs2_rdy = alloc_pkt.rs2_rdy | cdb_match(alloc_pkt.rs2_paddr);
        if (st_tag_pkt.valid && st_tag_pkt.store_tag == alloc_pkt.store_tag)
            in_pkt.store_tag_done = 1'b1;
        if (br_clear) in_pkt.bmask[br_pkt.br_bit] = 1'b0;
    end

    always_comb begin
        wake1    = '0;
        wake2    = '0;
        killed   = '0;
        eligible = '0;
        rs1_now  = 1'b0;
        rs2_now  = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            wake1[i]  = cdb_match(entry_q[i].rs1_paddr);
            wake2[i]  = cdb_match(entry_q[i].rs2_paddr);
            killed[i] = br_kill && entry_q[i].bmask[br_pkt.br_bit];
`ifdef LSIQ_CDB_BYPASS_EN
            rs1_now = entry_q[i].rs1_rdy | wake1[i];
            rs2_now = entry_q[i].rs2_rdy | wake2[i];
`else
            rs1_now = entry_q[i].rs1_rdy;
            rs2_now = entry_q[i].rs2_rdy;
`endif
            eligible[i] = valid_q[i] && !killed[i]
                          && src_ready(entry_q[i].i_use_rs1, rs1_now)
                          && (entry_q[i].is_store ? src_ready(entry_q[i].i_use_rs2, rs2_now)
                                                  : entry_q[i].store_tag_done);
        end
    end

    lsiq_age_matrix #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc_oh (alloc_oh),
        .valid    (valid_q),
        .eligible (eligible),
        .oldest_oh(oldest_oh)
    );

    assign iss_valid = |eligible;
    assign iss_fire  = iss_valid && iss_ready;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (oldest_oh[i]) sel_idx = IDX_W'(i);
    end

    always_comb begin
        iss_pkt = '0;
        if (iss_valid) begin
            iss_pkt = entry_q[sel_idx];
            if (br_clear) iss_pkt.bmask[br_pkt.br_bit] = 1'b0;
        end
        prf_ren_pkt.rs1_ren    = iss_fire && iss_pkt.i_use_rs1;
        prf_ren_pkt.rs2_ren    = iss_fire && iss_pkt.i_use_rs2;
        prf_addr_pkt.rs1_paddr = iss_fire ? iss_pkt.rs1_paddr : '0;
        prf_addr_pkt.rs2_paddr = iss_fire ? iss_pkt.rs2_paddr : '0;
    end

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entry_d[i]         = entry_q[i];
            entry_d[i].rs1_rdy = entry_q[i].rs1_rdy | wake1[i];
            entry_d[i].rs2_rdy = entry_q[i].rs2_rdy | wake2[i];
            if (st_tag_pkt.valid && st_tag_pkt.store_tag == entry_q[i].store_tag)
                entry_d[i].store_tag_done = 1'b1;
            if (br_clear) entry_d[i].bmask[br_pkt.br_bit] = 1'b0;
            valid_d[i] = valid_q[i] && !killed[i] && !(iss_fire && oldest_oh[i]);
            if (alloc_oh[i]) begin
                entry_d[i] = in_pkt;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) entry_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= CNT_W'($countones(valid_d));
            for (int i = 0; i < QUEUE_DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

endmodule

// File: tb/tb_ld_st_issue_station.sv
// Directed bench for ld_st_issue_station; expectations follow
// LSIQ_CDB_BYPASS_EN where wakeup timing differs.
module tb_ld_st_issue_station;
    import ld_st_issue_station_pkg::*;

    logic            clk;
    logic            rst;
    logic            alloc_valid;
    ld_st_data_pkt_t alloc_pkt;
    logic            alloc_ready;
    cdb_pkt_t        cdb [2];
    br_resolve_pkt_t br_pkt;
    st_tag_pkt_t     st_tag_pkt;
    logic            iss_valid;
    logic            iss_ready;
    ld_st_data_pkt_t iss_pkt;
    reg_ren_pkt_t    prf_ren_pkt;
    reg_addr_pkt_t   prf_addr_pkt;
    logic [3:0]      occupancy;

    int total = 0;
    int bad   = 0;
    ld_st_data_pkt_t exp_pkt;

    ld_st_issue_station #(.QUEUE_DEPTH(8), .NUM_CDB(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_pkt   (alloc_pkt),
        .alloc_ready (alloc_ready),
        .cdb_pkt     (cdb),
        .br_pkt      (br_pkt),
        .st_tag_pkt  (st_tag_pkt),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_pkt     (iss_pkt),
        .prf_ren_pkt (prf_ren_pkt),
        .prf_addr_pkt(prf_addr_pkt),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ld_st_data_pkt_t mk(input logic [5:0] rd, input logic [5:0] rs1,
                                           input logic [5:0] rs2, input logic u1, input logic u2,
                                           input logic r1, input logic r2, input logic [3:0] bm,
                                           input logic [3:0] tag, input logic done, input logic st);
        ld_st_data_pkt_t p;
        p = '0;
        p.rd_paddr = rd;  p.rs1_paddr = rs1; p.rs2_paddr = rs2;
        p.i_use_rs1 = u1; p.i_use_rs2 = u2;  p.rs1_rdy = r1; p.rs2_rdy = r2;
        p.bmask = bm;     p.store_tag = tag; p.store_tag_done = done; p.is_store = st;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_pkt   = '0;
        cdb[0]      = '0;
        cdb[1]      = '0;
        br_pkt      = '0;
        st_tag_pkt  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; iss_ready = 1'b0; idle();
        #1 rst = 1'b0;
        #12;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%0b exp=1", alloc_ready); end
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_iss_valid got=%0b exp=0", iss_valid); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
        total++; if (prf_ren_pkt !== 2'b00 || prf_addr_pkt !== 12'h000) begin bad++;
            $display("FAIL rst_prf got=%0h/%0h exp=0/0", prf_ren_pkt, prf_addr_pkt); end
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        iss_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            alloc_valid = 1'b1;
            alloc_pkt   = mk(6'(10 + k), 6'(1 + k), 6'd0, 1, 0, 1, 0, 4'h0, 4'h0, 1, 0);
            #1;
            total++; if (occupancy !== 4'(k)) begin bad++; $display("FAIL fill_occ got=%0d exp=%0d", occupancy, k); end
            tick();
        end
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd40, 6'd2, 6'd0, 1, 0, 1, 0, 4'h0, 4'h0, 1, 0);
        iss_ready   = 1'b1;
        #1;
        total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_alloc_ready got=%0b exp=0", alloc_ready); end
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (iss_valid !== 1'b1 || iss_pkt.rd_paddr !== 6'(10 + k)) begin bad++;
                $display("FAIL drain_order got=%0b/%0d exp=1/%0d", iss_valid, iss_pkt.rd_paddr, 10 + k); end
            total++; if (prf_ren_pkt !== 2'b10 || prf_addr_pkt.rs1_paddr !== 6'(1 + k)) begin bad++;
                $display("FAIL drain_prf got=%0b/%0d exp=10/%0d", prf_ren_pkt, prf_addr_pkt.rs1_paddr, 1 + k); end
            tick();
            if (k == 0) idle();
        end
        iss_ready = 1'b0;
        #1;
        total++; if (occupancy !== 4'd0 || iss_valid !== 1'b0) begin bad++;
            $display("FAIL drain_empty got=%0d/%0b exp=0/0", occupancy, iss_valid); end
        tick();
    endtask

    task automatic test_store_wakeup();
        iss_ready   = 1'b1;
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd0, 6'd3, 6'd12, 1, 1, 1, 0, 4'h0, 4'h1, 0, 1);
        tick();
        idle();
        #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL st_wait got=%0b exp=0", iss_valid); end
        cdb[1] = '{cdb_broadcast: 1'b1, paddr: 6'd12};
        #1;
`ifdef LSIQ_CDB_BYPASS_EN
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL st_bypass got=%0b exp=1", iss_valid); end
        total++; if (prf_ren_pkt !== 2'b11 || prf_addr_pkt !== {6'd3, 6'd12}) begin bad++;
            $display("FAIL st_prf got=%0b/%0h exp=11/%0h", prf_ren_pkt, prf_addr_pkt, {6'd3, 6'd12}); end
        tick();
        idle();
`else
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL st_nobypass got=%0b exp=0", iss_valid); end
        tick();
        idle();
        #1;
        total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL st_late got=%0b exp=1", iss_valid); end
        total++; if (prf_ren_pkt !== 2'b11 || prf_addr_pkt !== {6'd3, 6'd12}) begin bad++;
            $display("FAIL st_prf got=%0b/%0h exp=11/%0h", prf_ren_pkt, prf_addr_pkt, {6'd3, 6'd12}); end
        tick();
`endif
        #1;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL st_done_occ got=%0d exp=0", occupancy); end
        tick();
    endtask

    task automatic test_store_tag_order();
        iss_ready   = 1'b0;
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd1, 6'd4, 6'd5, 1, 1, 1, 1, 4'h0, 4'h2, 0, 1);
        tick();
        alloc_pkt   = mk(6'd2, 6'd6, 6'd0, 1, 0, 1, 0, 4'h0, 4'h3, 0, 0);
        tick();
        idle();
        iss_ready = 1'b1;
        #1;
        total++; if (iss_valid !== 1'b1 || iss_pkt.rd_paddr !== 6'd1 || iss_pkt.is_store !== 1'b1) begin bad++;
            $display("FAIL tag_store_first got=%0b/%0d exp=1/1", iss_valid, iss_pkt.rd_paddr); end
        tick();
        #1;
        total++; if (iss_valid !== 1'b0 || occupancy !== 4'd1) begin bad++;
            $display("FAIL tag_load_blocked got=%0b/%0d exp=0/1", iss_valid, occupancy); end
        st_tag_pkt = '{valid: 1'b1, store_tag: 4'h3};
        #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL tag_same_cycle got=%0b exp=0", iss_valid); end
        tick();
        idle();
        #1;
        total++; if (iss_valid !== 1'b1 || iss_pkt.rd_paddr !== 6'd2) begin bad++;
            $display("FAIL tag_load_issue got=%0b/%0d exp=1/2", iss_valid, iss_pkt.rd_paddr); end
        tick();
        #1;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL tag_done_occ got=%0d exp=0", occupancy); end
        tick();
    endtask

    task automatic test_mispredict();
        iss_ready   = 1'b0;
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd20, 6'd7, 6'd0, 1, 0, 1, 0, 4'b0100, 4'h0, 1, 0);
        tick();
        alloc_pkt   = mk(6'd21, 6'd8, 6'd0, 1, 0, 1, 0, 4'b0001, 4'h0, 1, 0);
        tick();
        idle();
        #1;
        total++; if (occupancy !== 4'd2 || iss_pkt.rd_paddr !== 6'd20) begin bad++;
            $display("FAIL br_pre got=%0d/%0d exp=2/20", occupancy, iss_pkt.rd_paddr); end
        br_pkt = '{valid: 1'b1, mispred: 1'b1, br_bit: 2'd2};
        #1;
        total++; if (iss_valid !== 1'b1 || iss_pkt.rd_paddr !== 6'd21) begin bad++;
            $display("FAIL br_mask_same_cycle got=%0b/%0d exp=1/21", iss_valid, iss_pkt.rd_paddr); end
        tick();
        idle();
        #1;
        total++; if (occupancy !== 4'd1 || iss_pkt.rd_paddr !== 6'd21) begin bad++;
            $display("FAIL br_squash got=%0d/%0d exp=1/21", occupancy, iss_pkt.rd_paddr); end
        br_pkt = '{valid: 1'b1, mispred: 1'b0, br_bit: 2'd0};
        #1;
        total++; if (iss_pkt.bmask !== 4'b0000) begin bad++; $display("FAIL br_clear_comb got=%0b exp=0000", iss_pkt.bmask); end
        tick();
        idle();
        #1;
        total++; if (iss_pkt.bmask !== 4'b0000) begin bad++; $display("FAIL br_clear_reg got=%0b exp=0000", iss_pkt.bmask); end
        br_pkt      = '{valid: 1'b1, mispred: 1'b1, br_bit: 2'd3};
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd22, 6'd9, 6'd0, 1, 0, 1, 0, 4'b1000, 4'h0, 1, 0);
        #1;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL br_drop_ready got=%0b exp=1", alloc_ready); end
        tick();
        idle();
        #1;
        total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL br_drop_occ got=%0d exp=1", occupancy); end
        br_pkt      = '{valid: 1'b1, mispred: 1'b0, br_bit: 2'd1};
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd23, 6'd9, 6'd0, 1, 0, 1, 0, 4'b0010, 4'h0, 1, 0);
        tick();
        idle();
        iss_ready = 1'b1;
        #1;
        total++; if (iss_pkt.rd_paddr !== 6'd21) begin bad++; $display("FAIL br_b_issue got=%0d exp=21", iss_pkt.rd_paddr); end
        tick();
        #1;
        total++; if (iss_pkt.rd_paddr !== 6'd23 || iss_pkt.bmask !== 4'b0000) begin bad++;
            $display("FAIL br_alloc_clear got=%0d/%0b exp=23/0000", iss_pkt.rd_paddr, iss_pkt.bmask); end
        tick();
        #1;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL br_done_occ got=%0d exp=0", occupancy); end
        tick();
    endtask

    task automatic test_alloc_bypass();
        iss_ready   = 1'b1;
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd25, 6'd5, 6'd0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 0);
        cdb[0]      = '{cdb_broadcast: 1'b1, paddr: 6'd5};
        #1;
        total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL ab_empty got=%0b exp=0", iss_valid); end
        tick();
        idle();
        #1;
        total++; if (iss_valid !== 1'b1 || iss_pkt.rd_paddr !== 6'd25 || iss_pkt.rs1_rdy !== 1'b1) begin bad++;
            $display("FAIL ab_issue got=%0b/%0d/%0b exp=1/25/1", iss_valid, iss_pkt.rd_paddr, iss_pkt.rs1_rdy); end
        tick();
        #1;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL ab_occ got=%0d exp=0", occupancy); end
        tick();
    endtask

    task automatic test_stall_reset();
        iss_ready   = 1'b0;
        alloc_valid = 1'b1;
        alloc_pkt   = mk(6'd29, 6'd0, 6'd0, 1, 0, 0, 0, 4'h0, 4'h0, 1, 0);
        tick();
        exp_pkt     = mk(6'd30, 6'd11, 6'd0, 1, 0, 1, 0, 4'h0, 4'h0, 1, 0);
        alloc_pkt   = exp_pkt;
        tick();
        alloc_pkt   = mk(6'd31, 6'd13, 6'd0, 1, 0, 1, 0, 4'h0, 4'h0, 1, 0);
        tick();
        idle();
        cdb[0] = '{cdb_broadcast: 1'b1, paddr: 6'd0};
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (iss_valid !== 1'b1 || iss_pkt !== exp_pkt) begin bad++;
                $display("FAIL stall_stable got=%0b/%0h exp=1/%0h", iss_valid, iss_pkt, exp_pkt); end
            total++; if (occupancy !== 4'd3) begin bad++; $display("FAIL stall_occ got=%0d exp=3", occupancy); end
            tick();
        end
        #2 rst = 1'b0;
        #1;
        total++; if (iss_valid !== 1'b0 || occupancy !== 4'd0) begin bad++;
            $display("FAIL mid_reset got=%0b/%0d exp=0/0", iss_valid, occupancy); end
        total++; if (alloc_ready !== 1'b1 || prf_ren_pkt !== 2'b00) begin bad++;
            $display("FAIL mid_reset_out got=%0b/%0b exp=1/00", alloc_ready, prf_ren_pkt); end
        idle();
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_store_wakeup();
        test_store_tag_order();
        test_mispredict();
        test_alloc_bypass();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
